// File: rtl/punc_control_if.sv
// rtl/punc_control_if.sv - Instruction/flag inputs and datapath control strobes of punc_control
interface punc_control_if;
    logic [15:0] ir;
    logic        nzp_match;
    logic        pc_ld;
    logic        pc_clr;
    logic        pc_inc;
    logic [1:0]  pc_sel;
    logic        ir_ld;
    logic        ir_clr;
    logic        dmem_rd;
    logic        dmem_wr;
    logic [1:0]  dmem_r_addr_sel;
    logic [1:0]  dmem_w_addr_sel;
    logic [1:0]  rf_w_data_sel;
    logic        rf_w_addr_sel;
    logic        rf_w_wr;
    logic        rf_rp_addr_sel;
    logic        rf_rp_rd;
    logic        rf_rq_rd;
    logic        temp_ld;
    logic        nzp_ld;
    logic        nzp_clr;
    logic [1:0]  alu_sel;
    logic        alu_in_a_sel;
    logic        halted;

    modport master (
        input  ir, nzp_match,
        output pc_ld, pc_clr, pc_inc, pc_sel, ir_ld, ir_clr, dmem_rd, dmem_wr,
               dmem_r_addr_sel, dmem_w_addr_sel, rf_w_data_sel, rf_w_addr_sel,
               rf_w_wr, rf_rp_addr_sel, rf_rp_rd, rf_rq_rd, temp_ld, nzp_ld,
               nzp_clr, alu_sel, alu_in_a_sel, halted
    );

    modport slave (
        output ir, nzp_match,
        input  pc_ld, pc_clr, pc_inc, pc_sel, ir_ld, ir_clr, dmem_rd, dmem_wr,
               dmem_r_addr_sel, dmem_w_addr_sel, rf_w_data_sel, rf_w_addr_sel,
               rf_w_wr, rf_rp_addr_sel, rf_rp_rd, rf_rq_rd, temp_ld, nzp_ld,
               nzp_clr, alu_sel, alu_in_a_sel, halted
    );
endinterface

// File: rtl/punc_control.sv
// rtl/punc_control.sv - Multi-cycle FETCH/DECODE/EXECUTE sequencer decoding datapath strobes from state and ir
module punc_control (
    input  logic                  clk,
    input  logic                  rst,
    punc_control_if.master        bus
);
    typedef enum logic [2:0] {
        ST_FETCH    = 3'd0,
        ST_DECODE   = 3'd1,
        ST_EXECUTE  = 3'd2,
        ST_EXECUTE2 = 3'd3,
        ST_HALT     = 3'd4
    } state_t;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    state_t     state_q, state_d;
    logic [3:0] opcode;

    assign opcode = bus.ir[15:12];

    always_ff @(posedge clk) begin
        state_q <= state_d;
    end

    // rst overrides everything, including a held HALT, and restarts at FETCH.
    always_comb begin
        state_d = state_q;
        if (rst) begin
            state_d = ST_FETCH;
        end else begin
            case (state_q)
                ST_FETCH:    state_d = ST_DECODE;
                ST_DECODE:   state_d = (opcode == OP_HALT) ? ST_HALT : ST_EXECUTE;
                ST_EXECUTE:  state_d = (opcode == OP_LDI || opcode == OP_STI) ? ST_EXECUTE2 : ST_FETCH;
                ST_EXECUTE2: state_d = ST_FETCH;
                ST_HALT:     state_d = ST_HALT;
                default:     state_d = ST_FETCH;
            endcase
        end
    end

    always_comb begin
        bus.pc_ld           = 1'b0;
        bus.pc_clr          = 1'b0;
        bus.pc_inc          = 1'b0;
        bus.pc_sel          = 2'd0;
        bus.ir_ld           = 1'b0;
        bus.ir_clr          = 1'b0;
        bus.dmem_rd         = 1'b0;
        bus.dmem_wr         = 1'b0;
        bus.dmem_r_addr_sel = 2'd0;
        bus.dmem_w_addr_sel = 2'd0;
        bus.rf_w_data_sel   = 2'd0;
        bus.rf_w_addr_sel   = 1'b0;
        bus.rf_w_wr         = 1'b0;
        bus.rf_rp_addr_sel  = 1'b0;
        bus.rf_rp_rd        = 1'b0;
        bus.rf_rq_rd        = 1'b0;
        bus.temp_ld         = 1'b0;
        bus.nzp_ld          = 1'b0;
        bus.nzp_clr         = 1'b0;
        bus.alu_sel         = 2'd0;
        bus.alu_in_a_sel    = 1'b0;
        bus.halted          = 1'b0;

        if (rst) begin
            bus.pc_clr  = 1'b1;
            bus.ir_clr  = 1'b1;
            bus.nzp_clr = 1'b1;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    bus.dmem_rd = 1'b1;
                    bus.ir_ld   = 1'b1;
                end
                ST_DECODE: begin
                    bus.pc_inc = 1'b1;
                end
                ST_EXECUTE: begin
                    case (opcode)
                        OP_ADD, OP_AND, OP_NOT: begin
                            bus.rf_w_wr  = 1'b1;
                            bus.nzp_ld   = 1'b1;
                            bus.rf_rq_rd = 1'b1;
                            bus.alu_sel  = (opcode == OP_ADD) ? 2'd0 :
                                           (opcode == OP_AND) ? 2'd1 : 2'd2;
                            // ir[5] selects immediate vs. register second operand.
                            if (opcode != OP_NOT) begin
                                bus.alu_in_a_sel = bus.ir[5];
                                if (!bus.ir[5]) begin
                                    bus.rf_rp_addr_sel = 1'b1;
                                    bus.rf_rp_rd       = 1'b1;
                                end
                            end
                        end
                        OP_BR: begin
                            bus.pc_ld = bus.nzp_match;
                        end
                        OP_JMP: begin
                            bus.pc_ld    = 1'b1;
                            bus.pc_sel   = 2'd2;
                            bus.rf_rq_rd = 1'b1;
                        end
                        OP_JSR: begin
                            bus.rf_w_wr       = 1'b1;
                            bus.rf_w_addr_sel = 1'b1;
                            bus.rf_w_data_sel = 2'd2;
                            bus.pc_ld         = 1'b1;
                            bus.pc_sel        = bus.ir[11] ? 2'd1 : 2'd2;
                        end
                        OP_LD, OP_LDR: begin
                            bus.dmem_rd         = 1'b1;
                            bus.dmem_r_addr_sel = (opcode == OP_LD) ? 2'd1 : 2'd3;
                            bus.rf_w_wr         = 1'b1;
                            bus.rf_w_data_sel   = 2'd1;
                            bus.nzp_ld          = 1'b1;
                        end
                        OP_LEA: begin
                            bus.rf_w_wr       = 1'b1;
                            bus.rf_w_data_sel = 2'd3;
                        end
                        OP_ST, OP_STR: begin
                            bus.dmem_wr         = 1'b1;
                            bus.dmem_w_addr_sel = (opcode == OP_ST) ? 2'd0 : 2'd2;
                            bus.rf_rp_rd        = 1'b1;
                        end
                        OP_LDI, OP_STI: begin
                            bus.dmem_rd         = 1'b1;
                            bus.dmem_r_addr_sel = 2'd1;
                            bus.temp_ld         = 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_EXECUTE2: begin
                    if (opcode == OP_LDI) begin
                        bus.dmem_rd         = 1'b1;
                        bus.dmem_r_addr_sel = 2'd2;
                        bus.rf_w_wr         = 1'b1;
                        bus.rf_w_data_sel   = 2'd1;
                        bus.nzp_ld          = 1'b1;
                    end else begin
                        bus.dmem_wr         = 1'b1;
                        bus.dmem_w_addr_sel = 2'd1;
                        bus.rf_rp_rd        = 1'b1;
                    end
                end
                ST_HALT: begin
                    bus.halted = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_punc_control.sv
// tb/tb_punc_control.sv - Scoreboarded random-instruction bench for punc_control
module tb_punc_control;
    typedef struct packed {
        logic       pc_ld;
        logic       pc_clr;
        logic       pc_inc;
        logic [1:0] pc_sel;
        logic       ir_ld;
        logic       ir_clr;
        logic       dmem_rd;
        logic       dmem_wr;
        logic [1:0] dmem_r_addr_sel;
        logic [1:0] dmem_w_addr_sel;
        logic [1:0] rf_w_data_sel;
        logic       rf_w_addr_sel;
        logic       rf_w_wr;
        logic       rf_rp_addr_sel;
        logic       rf_rp_rd;
        logic       rf_rq_rd;
        logic       temp_ld;
        logic       nzp_ld;
        logic       nzp_clr;
        logic [1:0] alu_sel;
        logic       alu_in_a_sel;
        logic       halted;
    } ctl_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    ctl_t sb[$];
    ctl_t act;
    string tag_q[$];

    punc_control_if bus ();
    punc_control dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    assign act = '{bus.pc_ld, bus.pc_clr, bus.pc_inc, bus.pc_sel, bus.ir_ld, bus.ir_clr,
                   bus.dmem_rd, bus.dmem_wr, bus.dmem_r_addr_sel, bus.dmem_w_addr_sel,
                   bus.rf_w_data_sel, bus.rf_w_addr_sel, bus.rf_w_wr, bus.rf_rp_addr_sel,
                   bus.rf_rp_rd, bus.rf_rq_rd, bus.temp_ld, bus.nzp_ld, bus.nzp_clr,
                   bus.alu_sel, bus.alu_in_a_sel, bus.halted};

    function automatic ctl_t c_rst();
        ctl_t c = '0;
        c.pc_clr = 1'b1; c.ir_clr = 1'b1; c.nzp_clr = 1'b1;
        return c;
    endfunction

    function automatic ctl_t c_fetch();
        ctl_t c = '0;
        c.dmem_rd = 1'b1; c.ir_ld = 1'b1;
        return c;
    endfunction

    function automatic ctl_t c_decode();
        ctl_t c = '0;
        c.pc_inc = 1'b1;
        return c;
    endfunction

    function automatic ctl_t c_halt();
        ctl_t c = '0;
        c.halted = 1'b1;
        return c;
    endfunction

    // Reference: what each instruction asks of the datapath in its execute step(s).
    function automatic ctl_t c_exec(input logic [15:0] i, input logic m, input bit second);
        ctl_t c = '0;
        string mn;
        case (i[15:12])
            4'h0: mn = "BR";   4'h1: mn = "ADD";  4'h2: mn = "LD";   4'h3: mn = "ST";
            4'h4: mn = "JSR";  4'h5: mn = "AND";  4'h6: mn = "LDR";  4'h7: mn = "STR";
            4'h9: mn = "NOT";  4'hA: mn = "LDI";  4'hB: mn = "STI";  4'hC: mn = "JMP";
            4'hE: mn = "LEA";  default: mn = "NOP";
        endcase
        if (second) begin
            if (mn == "LDI") begin
                c.dmem_rd = 1; c.dmem_r_addr_sel = 2; c.rf_w_wr = 1; c.rf_w_data_sel = 1; c.nzp_ld = 1;
            end else begin
                c.dmem_wr = 1; c.dmem_w_addr_sel = 1; c.rf_rp_rd = 1;
            end
            return c;
        end
        if (mn == "ADD" || mn == "AND" || mn == "NOT") begin
            c.rf_w_wr = 1; c.nzp_ld = 1; c.rf_rq_rd = 1;
            c.alu_sel = (mn == "ADD") ? 2'd0 : (mn == "AND") ? 2'd1 : 2'd2;
            if (mn != "NOT") begin
                c.alu_in_a_sel = i[5];
                c.rf_rp_addr_sel = ~i[5];
                c.rf_rp_rd = ~i[5];
            end
        end
        if (mn == "BR")  c.pc_ld = m;
        if (mn == "JMP") begin c.pc_ld = 1; c.pc_sel = 2; c.rf_rq_rd = 1; end
        if (mn == "JSR") begin
            c.rf_w_wr = 1; c.rf_w_addr_sel = 1; c.rf_w_data_sel = 2; c.pc_ld = 1;
            c.pc_sel = i[11] ? 2'd1 : 2'd2;
        end
        if (mn == "LD" || mn == "LDR") begin
            c.dmem_rd = 1; c.dmem_r_addr_sel = (mn == "LD") ? 2'd1 : 2'd3;
            c.rf_w_wr = 1; c.rf_w_data_sel = 1; c.nzp_ld = 1;
        end
        if (mn == "LEA") begin c.rf_w_wr = 1; c.rf_w_data_sel = 3; end
        if (mn == "ST" || mn == "STR") begin
            c.dmem_wr = 1; c.dmem_w_addr_sel = (mn == "ST") ? 2'd0 : 2'd2; c.rf_rp_rd = 1;
        end
        if (mn == "LDI" || mn == "STI") begin c.dmem_rd = 1; c.dmem_r_addr_sel = 1; c.temp_ld = 1; end
        return c;
    endfunction

    task automatic step(input logic r, input logic [15:0] i, input logic m, input ctl_t e, input string tag);
        @(posedge clk);
        #1;
        rst = r;
        bus.ir = i;
        bus.nzp_match = m;
        sb.push_back(e);
        tag_q.push_back(tag);
    endtask

    // One instruction; rst_at < phase count injects a reset in that phase and abandons the rest.
    task automatic run_instr(input logic [15:0] i, input logic m, input int rst_at, input int halt_cycles);
        ctl_t ph[$];
        ph.push_back(c_fetch());
        ph.push_back(c_decode());
        if (i[15:12] == 4'hF) begin
            for (int k = 0; k < halt_cycles; k++) ph.push_back(c_halt());
        end else begin
            ph.push_back(c_exec(i, m, 0));
            if (i[15:12] == 4'hA || i[15:12] == 4'hB) ph.push_back(c_exec(i, m, 1));
        end
        foreach (ph[k]) begin
            if (k == rst_at) begin
                step(1'b1, i, m, c_rst(), $sformatf("rst_in_ph%0d_ir%04h", k, i));
                return;
            end
            step(1'b0, i, m, ph[k], $sformatf("ph%0d_ir%04h", k, i));
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            ctl_t e;
            string t;
            e = sb.pop_front();
            t = tag_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %07h want %07h", t, act, e);
            end
            checks++;
            if (!$onehot0({act.pc_ld, act.pc_inc, act.pc_clr}) || (act.dmem_rd && act.dmem_wr)) begin
                errors++;
                $display("FAIL excl_%s: got %07h want strobes mutually exclusive", t, act);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ir = 16'h0;
        bus.nzp_match = 1'b0;
        step(1'b1, 16'h0, 1'b0, c_rst(), "reset");
        run_instr(16'h1261, 1'b0, 9, 0);
        run_instr(16'h0405, 1'b0, 9, 0);
        run_instr(16'h0405, 1'b1, 9, 0);
        run_instr(16'hA202, 1'b0, 9, 0);
        run_instr(16'hB202, 1'b0, 3, 0);
        run_instr(16'h1261, 1'b1, 9, 0);
        for (int n = 0; n < 300; n++) begin
            logic [15:0] i;
            int ra;
            i = 16'($urandom);
            i[15:12] = 4'($urandom_range(0, 14));
            ra = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : 9;
            run_instr(i, 1'($urandom), ra, 0);
        end
        run_instr(16'hF025, 1'b0, 99, 22);
        step(1'b1, 16'hF025, 1'b0, c_rst(), "halt_rst");
        run_instr(16'h5020, 1'b1, 9, 0);
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/punc_control.md
PUNC_CONTROL -- requirements
Module: punc_control

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 ir  input  16  current instruction register contents from datapath.
REQ-004 nzp_match  input  1  high when the ir[11:9] condition mask matches the stored n/z/p flags, or the mask is 000.
REQ-005 pc_ld, pc_clr, pc_inc  output  1 each  PC load, clear and increment strobes.
REQ-006 pc_sel  output  2  PC source: 0 = PC+sext(ir[8:0]); 1 = PC+sext(ir[10:0]); 2 = Rq data; 3 unused.
REQ-007 ir_ld, ir_clr  output  1 each  IR load and clear strobes.
REQ-008 dmem_rd, dmem_wr  output  1 each  memory read enable and write enable (write at clock edge).
REQ-009 dmem_r_addr_sel  output  2  read address: 0 = PC; 1 = PC+sext(ir[8:0]); 2 = temp; 3 = Rq+sext(ir[5:0]).
REQ-010 dmem_w_addr_sel  output  2  write address: 0 = PC+sext(ir[8:0]); 1 = temp; 2 = Rq+sext(ir[5:0]).
REQ-011 rf_w_data_sel  output  2  write data: 0 = ALU; 1 = memory read data; 2 = PC; 3 = PC+sext(ir[8:0]).
REQ-012 rf_w_addr_sel  output  1  write address: 0 = ir[11:9]; 1 = R7.
REQ-013 rf_w_wr  output  1  register file write enable.
REQ-014 rf_rp_addr_sel  output  1  Rp address: 0 = ir[11:9]; 1 = ir[2:0]. Rq address is always ir[8:6].
REQ-015 rf_rp_rd, rf_rq_rd  output  1 each  register file read enables.
REQ-016 temp_ld  output  1  load temp register from memory read data.
REQ-017 nzp_ld, nzp_clr  output  1 each  condition-flag load (from the register write data) and clear.
REQ-018 alu_sel  output  2  0 = ADD, 1 = AND, 2 = NOT, 3 = pass A.
REQ-019 alu_in_a_sel  output  1  ALU second operand: 0 = Rp data; 1 = sext(ir[4:0]). First operand is always Rq data.
REQ-020 halted  output  1  high while in HALT.

Function
REQ-021 States: FETCH, DECODE, EXECUTE, EXECUTE2, HALT; all outputs are decoded combinationally from state and ir; any output not named for a state SHALL be 0.
REQ-022 FETCH: dmem_rd=1, dmem_r_addr_sel=0, ir_ld=1; transition to DECODE.
REQ-023 DECODE: pc_inc=1; if ir[15:12]=1111 go to HALT, else go to EXECUTE.
REQ-024 EXECUTE for ADD(0001), AND(0101), NOT(1001): rf_w_wr=1, rf_w_data_sel=0, rf_w_addr_sel=0, nzp_ld=1, rf_rq_rd=1; alu_sel = 0/1/2 respectively; for ADD/AND, alu_in_a_sel=ir[5] and, when ir[5]=0, rf_rp_addr_sel=1 with rf_rp_rd=1.
REQ-025 EXECUTE for BR(0000): pc_ld=nzp_match, pc_sel=0.
REQ-026 EXECUTE for JMP(1100): pc_ld=1, pc_sel=2, rf_rq_rd=1.
REQ-027 EXECUTE for JSR/JSRR(0100): rf_w_wr=1, rf_w_addr_sel=1, rf_w_data_sel=2, pc_ld=1; pc_sel=1 when ir[11]=1, else pc_sel=2.
REQ-028 EXECUTE for LD(0010): dmem_rd=1, dmem_r_addr_sel=1; for LDR(0110): dmem_rd=1, dmem_r_addr_sel=3. In both cases rf_w_wr=1, rf_w_data_sel=1, nzp_ld=1.
REQ-029 EXECUTE for LEA(1110): rf_w_wr=1, rf_w_data_sel=3; nzp is not loaded.
REQ-030 EXECUTE for ST(0011): dmem_wr=1, dmem_w_addr_sel=0; for STR(0111): dmem_wr=1, dmem_w_addr_sel=2. In both cases rf_rp_addr_sel=0 and rf_rp_rd=1.
REQ-031 EXECUTE for LDI(1010) and STI(1011): dmem_rd=1, dmem_r_addr_sel=1, temp_ld=1; transition to EXECUTE2. All other opcodes, including unused 1000 and 1101, transition from EXECUTE to FETCH; the unused opcodes assert no outputs.
REQ-032 EXECUTE2 for LDI: dmem_rd=1, dmem_r_addr_sel=2, rf_w_wr=1, rf_w_data_sel=1, nzp_ld=1. EXECUTE2 for STI: dmem_wr=1, dmem_w_addr_sel=1, rf_rp_rd=1. Both transition to FETCH.
REQ-033 Latency: 3 cycles per instruction; LDI and STI take 4 cycles.
REQ-034 HALT: all strobes 0 and halted=1; the state is held until rst.
REQ-035 At most one of pc_ld, pc_inc and pc_clr SHALL be high in any cycle; the same applies to the pair dmem_rd/dmem_wr for the same address.

Reset
REQ-036 While rst=1: pc_clr=1, ir_clr=1, nzp_clr=1, and all other outputs including halted are 0; the next state is FETCH, regardless of the current state (including mid-instruction or HALT).

Verification
REQ-037 Assert rst for 1 cycle -> clear strobes=1 that cycle; the next cycle is FETCH with ir_ld=1, dmem_rd=1, dmem_r_addr_sel=0.
REQ-038 ir=0x1261 (ADD R1,R1,#1) -> EXECUTE shows rf_w_wr=1, alu_sel=0, alu_in_a_sel=1, nzp_ld=1; FETCH follows 3 cycles after the prior FETCH.
REQ-039 ir=0x0405 (BRz): with nzp_match=0 -> EXECUTE shows pc_ld=0; with nzp_match=1 -> pc_ld=1, pc_sel=0.
REQ-040 ir=0xA202 (LDI R1) -> EXECUTE shows temp_ld=1, dmem_r_addr_sel=1; EXECUTE2 shows dmem_r_addr_sel=2, rf_w_data_sel=1, rf_w_wr=1, nzp_ld=1; then FETCH.
REQ-041 ir=0xF025 -> after DECODE, halted=1 and all strobes stay 0 for 20+ cycles; rst returns the block to FETCH.
REQ-042 rst asserted in the STI EXECUTE2 cycle -> dmem_wr=0 that cycle; the next state is FETCH.
